// File: rtl/io_slave_mux.sv
// I/O page decoder between the bridge master bus and NDEV devices.
// Registers a shared request bus, returns the selected device's ack/data, and error-acks unmapped or silent devices.
module io_slave_mux #(
  parameter int          NDEV     = 8,
  parameter int          TIMEOUT  = 255,
  parameter logic [63:0] ERR_DATA = 64'hDEADDEADDEADDEAD
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 s_cyc_i,
  input  logic                 s_stb_i,
  output logic                 s_ack_o,
  output logic                 s_err_o,
  input  logic                 s_we_i,
  input  logic [7:0]           s_sel_i,
  input  logic [31:0]          s_adr_i,
  input  logic [63:0]          s_dat_i,
  output logic [63:0]          s_dat_o,
  output logic [NDEV-1:0]      d_cyc_o,
  output logic [NDEV-1:0]      d_stb_o,
  input  logic [NDEV-1:0]      d_ack_i,
  input  logic [64*NDEV-1:0]   d_dat_i,
  output logic                 d_we_o,
  output logic [7:0]           d_sel_o,
  output logic [31:0]          d_adr_o,
  output logic [63:0]          d_dat_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, ERR, RESP} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [15:0]       cnt_reg, cnt_next;
  logic [3:0]        idx_reg, idx_next;
  logic              s_ack_reg, s_ack_next;
  logic              s_err_reg, s_err_next;
  logic [63:0]       s_dat_reg, s_dat_next;
  logic [NDEV-1:0]   d_cyc_reg, d_cyc_next;
  logic              d_we_reg, d_we_next;
  logic [7:0]        d_sel_reg, d_sel_next;
  logic [31:0]       d_adr_reg, d_adr_next;
  logic [63:0]       d_dat_reg, d_dat_next;

  logic [NDEV-1:0]   page_dec;
  logic [NDEV-1:0]   idx_match;
  logic [63:0]       dat_or [NDEV+1];
  logic              mapped;
  logic              sel_ack;

  // A page with no matching decode bit is beyond NDEV, so the OR doubles as the range check.
  assign dat_or[0] = 64'd0;
  generate
    for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
      assign page_dec[gi]  = (s_adr_i[19:16] == 4'(gi));
      assign idx_match[gi] = (idx_reg == 4'(gi));
      assign dat_or[gi+1]  = dat_or[gi] | (idx_match[gi] ? d_dat_i[64*gi +: 64] : 64'd0);
    end
  endgenerate

  assign mapped  = (s_adr_i[31:20] == 12'hFFD) && (|page_dec);
  assign sel_ack = |(d_ack_i & idx_match);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      s_ack_reg <= 1'b0;
      s_err_reg <= 1'b0;
      s_dat_reg <= '0;
      d_cyc_reg <= '0;
      d_we_reg  <= 1'b0;
      d_sel_reg <= '0;
      d_adr_reg <= '0;
      d_dat_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      s_ack_reg <= s_ack_next;
      s_err_reg <= s_err_next;
      s_dat_reg <= s_dat_next;
      d_cyc_reg <= d_cyc_next;
      d_we_reg  <= d_we_next;
      d_sel_reg <= d_sel_next;
      d_adr_reg <= d_adr_next;
      d_dat_reg <= d_dat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    s_ack_next = s_ack_reg;
    s_err_next = s_err_reg;
    s_dat_next = s_dat_reg;
    d_cyc_next = d_cyc_reg;
    d_we_next  = d_we_reg;
    d_sel_next = d_sel_reg;
    d_adr_next = d_adr_reg;
    d_dat_next = d_dat_reg;
    case (state_reg)
      IDLE: begin
        if (s_cyc_i && s_stb_i && !s_ack_reg) begin
          d_adr_next = s_adr_i;
          d_we_next  = s_we_i;
          d_sel_next = s_sel_i;
          d_dat_next = s_dat_i;
          idx_next   = s_adr_i[19:16];
          if (mapped) begin
            d_cyc_next = page_dec;
            cnt_next   = '0;
            state_next = ACCESS;
          end else begin
            state_next = ERR;
          end
        end
      end
      ACCESS: begin
        if (sel_ack) begin
          s_dat_next = dat_or[NDEV];
          s_ack_next = 1'b1;
          s_err_next = 1'b0;
          d_cyc_next = '0;
          d_we_next  = 1'b0;
          state_next = RESP;
        end else if (!s_cyc_i) begin
          d_cyc_next = '0;
          d_we_next  = 1'b0;
          state_next = IDLE;
        end else if (cnt_reg == TO_LAST) begin
          d_cyc_next = '0;
          s_ack_next = 1'b1;
          s_err_next = 1'b1;
          s_dat_next = ERR_DATA;
          state_next = RESP;
        end else if (cnt_reg != 16'hFFFF) begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ERR: begin
        s_ack_next = 1'b1;
        s_err_next = 1'b1;
        s_dat_next = ERR_DATA;
        state_next = RESP;
      end
      RESP: begin
        // Read data is left in place after the ack drops.
        if (!s_stb_i || !s_cyc_i) begin
          s_ack_next = 1'b0;
          s_err_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_ack_o = s_ack_reg;
  assign s_err_o = s_err_reg;
  assign s_dat_o = s_dat_reg;
  assign d_cyc_o = d_cyc_reg;
  assign d_stb_o = d_cyc_reg;
  assign d_we_o  = d_we_reg;
  assign d_sel_o = d_sel_reg;
  assign d_adr_o = d_adr_reg;
  assign d_dat_o = d_dat_reg;

endmodule

// File: tb/tb_io_slave_mux.sv
// Directed bench for io_slave_mux (NDEV=8, TIMEOUT=4); cycle 0 is the cycle a request is presented.
module tb_io_slave_mux;

  localparam int          NDEV = 8;
  localparam logic [63:0] ERRD = 64'hDEADDEADDEADDEAD;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              s_cyc_i = 1'b0, s_stb_i = 1'b0, s_we_i = 1'b0;
  logic [7:0]        s_sel_i = '0;
  logic [31:0]       s_adr_i = '0;
  logic [63:0]       s_dat_i = '0;
  logic              s_ack_o, s_err_o;
  logic [63:0]       s_dat_o;
  logic [NDEV-1:0]   d_cyc_o, d_stb_o;
  logic [NDEV-1:0]   d_ack_i = '0;
  logic [64*NDEV-1:0] d_dat_i = '0;
  logic              d_we_o;
  logic [7:0]        d_sel_o;
  logic [31:0]       d_adr_o;
  logic [63:0]       d_dat_o;

  int n_cmp = 0;
  int n_bad = 0;

  io_slave_mux #(.NDEV(NDEV), .TIMEOUT(4), .ERR_DATA(ERRD)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_cyc_i(s_cyc_i), .s_stb_i(s_stb_i), .s_ack_o(s_ack_o), .s_err_o(s_err_o),
    .s_we_i(s_we_i), .s_sel_i(s_sel_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
    .d_cyc_o(d_cyc_o), .d_stb_o(d_stb_o), .d_ack_i(d_ack_i), .d_dat_i(d_dat_i),
    .d_we_o(d_we_o), .d_sel_o(d_sel_o), .d_adr_o(d_adr_o), .d_dat_o(d_dat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [31:0] adr, input logic we, input logic [7:0] sel, input logic [63:0] dat);
    s_cyc_i = 1'b1; s_stb_i = 1'b1; s_we_i = we; s_sel_i = sel; s_adr_i = adr; s_dat_i = dat;
  endtask

  task automatic release_bus();
    s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0; d_ack_i = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    n_cmp++; if ({s_ack_o, s_err_o, d_we_o} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b exp 000", {s_ack_o, s_err_o, d_we_o}); end
    n_cmp++; if ({d_cyc_o, d_stb_o} !== 16'h0) begin n_bad++; $display("FAIL rst_cyc: got %h exp 0000", {d_cyc_o, d_stb_o}); end
    n_cmp++; if ({s_dat_o, d_dat_o, d_adr_o, d_sel_o} !== '0) begin n_bad++; $display("FAIL rst_data: got s_dat %h d_dat %h d_adr %h d_sel %h exp 0", s_dat_o, d_dat_o, d_adr_o, d_sel_o); end
    $display("txn reset done");
  endtask

  task automatic test_read();
    req(32'hFFD3_0010, 1'b0, 8'hFF, 64'h0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (d_stb_o !== 8'b0000_1000 || s_ack_o !== 1'b0) begin n_bad++; $display("FAIL rd_stb_c%0d: got stb %b ack %b exp 00001000 0", c, d_stb_o, s_ack_o); end
      if (c == 4) begin d_ack_i = 8'b0000_1000; d_dat_i[64*3 +: 64] = 64'h1122334455667788; end
      tick();
    end
    d_ack_i = '0;
    n_cmp++; if ({s_ack_o, s_err_o} !== 2'b10) begin n_bad++; $display("FAIL rd_ack: got ack/err %b exp 10", {s_ack_o, s_err_o}); end
    n_cmp++; if (s_dat_o !== 64'h1122334455667788) begin n_bad++; $display("FAIL rd_data: got %h exp 1122334455667788", s_dat_o); end
    n_cmp++; if (d_adr_o !== 32'hFFD3_0010) begin n_bad++; $display("FAIL rd_adr: got %h exp ffd30010", d_adr_o); end
    tick();
    n_cmp++; if (s_ack_o !== 1'b1) begin n_bad++; $display("FAIL rd_hold: got %b exp 1", s_ack_o); end
    release_bus();
    tick();
    n_cmp++; if (s_ack_o !== 1'b0 || s_dat_o !== 64'h1122334455667788) begin n_bad++; $display("FAIL rd_drop: got ack %b dat %h exp 0 1122334455667788", s_ack_o, s_dat_o); end
    $display("txn read dev3 adr ffd30010 data %h", s_dat_o);
  endtask

  task automatic test_write();
    req(32'hFFD0_0000, 1'b1, 8'h0F, 64'hA5);
    tick();
    n_cmp++; if ({d_we_o, d_sel_o, d_stb_o} !== {1'b1, 8'h0F, 8'b0000_0001}) begin n_bad++; $display("FAIL wr_bus: got we %b sel %h stb %b exp 1 0f 00000001", d_we_o, d_sel_o, d_stb_o); end
    n_cmp++; if (d_dat_o !== 64'hA5) begin n_bad++; $display("FAIL wr_dat: got %h exp a5", d_dat_o); end
    d_ack_i = 8'b0000_0001; d_dat_i[63:0] = 64'h0BADF00D;
    tick();
    d_ack_i = '0;
    n_cmp++; if ({s_ack_o, s_err_o, d_we_o, d_stb_o} !== {3'b100, 8'h00}) begin n_bad++; $display("FAIL wr_ack: got ack %b err %b we %b stb %b exp 1 0 0 0", s_ack_o, s_err_o, d_we_o, d_stb_o); end
    n_cmp++; if (s_dat_o !== 64'h0BADF00D || d_dat_o !== 64'hA5) begin n_bad++; $display("FAIL wr_rdat: got s_dat %h d_dat %h exp 0badf00d a5", s_dat_o, d_dat_o); end
    release_bus();
    tick();
    $display("txn write dev0 sel 0f data a5 ack done");
  endtask

  task automatic test_unmapped(input logic [31:0] adr);
    req(adr, 1'b0, 8'hFF, 64'h0);
    tick();
    n_cmp++; if (d_cyc_o !== 8'h00 || s_ack_o !== 1'b0) begin n_bad++; $display("FAIL um_c1 %h: got cyc %b ack %b exp 0 0", adr, d_cyc_o, s_ack_o); end
    tick();
    n_cmp++; if ({s_ack_o, s_err_o, d_cyc_o} !== {2'b11, 8'h00} || s_dat_o !== ERRD) begin n_bad++; $display("FAIL um_c2 %h: got ack %b err %b cyc %b dat %h exp 1 1 0 deaddeaddeaddead", adr, s_ack_o, s_err_o, d_cyc_o, s_dat_o); end
    release_bus();
    tick();
    n_cmp++; if ({s_ack_o, s_err_o} !== 2'b00) begin n_bad++; $display("FAIL um_drop %h: got %b exp 00", adr, {s_ack_o, s_err_o}); end
    $display("txn unmapped adr %h err-ack", adr);
  endtask

  task automatic test_timeout(input logic ack_last);
    req(32'hFFD5_0000, 1'b0, 8'hFF, 64'h0);
    d_dat_i[64*5 +: 64] = 64'h5555_0000_AAAA_1234;
    tick();
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (d_stb_o !== 8'b0010_0000 || s_ack_o !== 1'b0) begin n_bad++; $display("FAIL to%0b_c%0d: got stb %b ack %b exp 00100000 0", ack_last, c, d_stb_o, s_ack_o); end
      if (c == 4 && ack_last) d_ack_i = 8'b0010_0000;
      tick();
    end
    d_ack_i = '0;
    if (ack_last) begin
      n_cmp++; if ({s_ack_o, s_err_o, d_stb_o} !== {2'b10, 8'h00} || s_dat_o !== 64'h5555_0000_AAAA_1234) begin n_bad++; $display("FAIL to_ackwin: got ack %b err %b stb %b dat %h exp 1 0 0 5555_0000_aaaa_1234", s_ack_o, s_err_o, d_stb_o, s_dat_o); end
    end else begin
      n_cmp++; if ({s_ack_o, s_err_o, d_stb_o} !== {2'b11, 8'h00} || s_dat_o !== ERRD) begin n_bad++; $display("FAIL to_expire: got ack %b err %b stb %b dat %h exp 1 1 0 deaddeaddeaddead", s_ack_o, s_err_o, d_stb_o, s_dat_o); end
    end
    release_bus();
    tick();
    $display("txn timeout dev5 ack_on_last=%0b err=%0b", ack_last, ack_last ? 1'b0 : 1'b1);
  endtask

  task automatic test_abort();
    req(32'hFFD1_0000, 1'b1, 8'h01, 64'h77);
    tick();
    d_ack_i = 8'b0000_0100;
    d_dat_i[64*2 +: 64] = 64'hBAD;
    tick();
    n_cmp++; if (d_stb_o !== 8'b0000_0010 || s_ack_o !== 1'b0) begin n_bad++; $display("FAIL ab_other_ack: got stb %b ack %b exp 00000010 0", d_stb_o, s_ack_o); end
    release_bus();
    tick();
    n_cmp++; if ({d_cyc_o, d_we_o, s_ack_o} !== 10'b0) begin n_bad++; $display("FAIL ab_drop: got cyc %b we %b ack %b exp 0 0 0", d_cyc_o, d_we_o, s_ack_o); end
    tick();
    n_cmp++; if (s_ack_o !== 1'b0) begin n_bad++; $display("FAIL ab_noack: got %b exp 0", s_ack_o); end
    $display("txn abort dev1 no ack");
  endtask

  task automatic test_reset_midflight();
    req(32'hFFD4_0008, 1'b1, 8'h33, 64'h44);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    release_bus();
    n_cmp++; if ({d_cyc_o, d_we_o, d_sel_o, d_adr_o, s_ack_o} !== '0) begin n_bad++; $display("FAIL rst_access: got cyc %b we %b sel %h adr %h ack %b exp 0", d_cyc_o, d_we_o, d_sel_o, d_adr_o, s_ack_o); end
    tick();
    req(32'hFFDA_0000, 1'b0, 8'hFF, 64'h0);
    tick(); tick();
    n_cmp++; if (s_ack_o !== 1'b1) begin n_bad++; $display("FAIL rst_resp_pre: got %b exp 1", s_ack_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    release_bus();
    n_cmp++; if ({s_ack_o, s_err_o, s_dat_o, d_adr_o} !== '0) begin n_bad++; $display("FAIL rst_resp: got ack %b err %b dat %h adr %h exp 0", s_ack_o, s_err_o, s_dat_o, d_adr_o); end
    tick();
    req(32'hFFD1_0020, 1'b0, 8'hFF, 64'h0);
    tick();
    n_cmp++; if (d_stb_o !== 8'b0000_0010) begin n_bad++; $display("FAIL post_rst_stb: got %b exp 00000010", d_stb_o); end
    d_ack_i = 8'b0000_0010; d_dat_i[64*1 +: 64] = 64'hCAFE_F00D_1234_5678;
    tick();
    d_ack_i = '0;
    n_cmp++; if ({s_ack_o, s_err_o} !== 2'b10 || s_dat_o !== 64'hCAFE_F00D_1234_5678) begin n_bad++; $display("FAIL post_rst_rd: got ack %b err %b dat %h exp 1 0 cafef00d12345678", s_ack_o, s_err_o, s_dat_o); end
    release_bus();
    tick();
    $display("txn reset in ACCESS/RESP then read dev1 %h", s_dat_o);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped(32'hFFD9_0000);
    test_unmapped(32'h1234_0000);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_abort();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
